// File: rtl/cart_mem_ctrl.sv
// Cartridge memory sequencer: arbitrates the single-port cartridge RAM between the ROM
// download stream (priority) and console CPU reads, and holds the console in reset while loading.
module cart_mem_ctrl #(
    parameter int unsigned AW     = 17,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned HOLD   = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_dl_active,
    input  logic          i_dl_valid,
    input  logic [AW-1:0] i_dl_addr,
    input  logic [7:0]    i_dl_data,
    output logic          o_dl_ready,
    input  logic          i_cpu_req,
    input  logic [AW-1:0] i_cpu_addr,
    output logic [7:0]    o_cpu_rdata,
    output logic          o_cpu_rvalid,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_wdata,
    output logic          o_mem_we,
    output logic          o_mem_re,
    input  logic [7:0]    i_mem_rdata,
    output logic [AW:0]   o_cart_size,
    output logic          o_sys_resb
);

    localparam int unsigned SW = AW + 1;
    localparam int unsigned LW = 3;
    localparam int unsigned HW = 8;

    typedef enum logic [1:0] {S_IDLE, S_DL_WR, S_RD_WAIT} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_dl_ready, w_dl_ready_nxt;
    logic            r_cpu_rvalid, w_cpu_rvalid_nxt;
    logic [7:0]      r_cpu_rdata, w_cpu_rdata_nxt;
    logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [7:0]      r_mem_wdata, w_mem_wdata_nxt;
    logic            r_mem_we, w_mem_we_nxt;
    logic            r_mem_re, w_mem_re_nxt;
    logic [SW-1:0]   r_cart_size, w_cart_size_nxt;
    logic            r_sys_resb, w_sys_resb_nxt;
    logic [HW-1:0]   r_hold, w_hold_nxt;
    logic [LW-1:0]   r_lat, w_lat_nxt;
    logic            r_dl_mode, w_dl_mode_nxt;

    logic            w_accept;
    logic            w_in_range;
    logic [SW-1:0]   w_wr_end;

    assign w_accept   = i_dl_valid & r_dl_ready;
    assign w_in_range = SW'(i_cpu_addr) < r_cart_size;
    assign w_wr_end   = SW'(r_mem_addr) + SW'(1);

    // State and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_dl_ready   <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_cpu_rdata  <= 8'hFF;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_re     <= 1'b0;
            r_cart_size  <= '0;
            r_sys_resb   <= 1'b0;
            r_hold       <= HW'(HOLD);
            r_lat        <= '0;
            r_dl_mode    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dl_ready   <= w_dl_ready_nxt;
            r_cpu_rvalid <= w_cpu_rvalid_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_re     <= w_mem_re_nxt;
            r_cart_size  <= w_cart_size_nxt;
            r_sys_resb   <= w_sys_resb_nxt;
            r_hold       <= w_hold_nxt;
            r_lat        <= w_lat_nxt;
            r_dl_mode    <= w_dl_mode_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt      = r_state;
        w_cpu_rvalid_nxt = 1'b0;
        w_cpu_rdata_nxt  = r_cpu_rdata;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_mem_we_nxt     = 1'b0;
        w_mem_re_nxt     = 1'b0;
        w_cart_size_nxt  = r_cart_size;
        w_lat_nxt        = r_lat;
        w_sys_resb_nxt   = r_sys_resb;
        w_hold_nxt       = r_hold;
        w_dl_mode_nxt    = r_dl_mode;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = S_DL_WR;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_addr_nxt  = i_dl_addr;
                    w_mem_wdata_nxt = i_dl_data;
                end else if (!i_dl_active && i_cpu_req && r_sys_resb) begin
                    if (w_in_range) begin
                        w_state_nxt    = S_RD_WAIT;
                        w_mem_re_nxt   = 1'b1;
                        w_mem_addr_nxt = i_cpu_addr;
                        w_lat_nxt      = LW'(RD_LAT);
                    end else begin
                        w_cpu_rdata_nxt  = 8'hFF;
                        w_cpu_rvalid_nxt = 1'b1;
                    end
                end
                if (i_dl_active && !r_dl_mode) begin
                    w_cart_size_nxt = '0;
                end
            end
            S_DL_WR: begin
                w_state_nxt = S_IDLE;
                if (w_wr_end > r_cart_size) begin
                    w_cart_size_nxt = w_wr_end;
                end
            end
            S_RD_WAIT: begin
                if (r_lat == '0) begin
                    w_state_nxt      = S_IDLE;
                    w_cpu_rdata_nxt  = i_mem_rdata;
                    w_cpu_rvalid_nxt = 1'b1;
                end else begin
                    w_lat_nxt = r_lat - LW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Console reset: held while loading; the cycle DL_ACTIVE falls is the first hold cycle
        if ((r_state == S_IDLE && i_dl_active) || (r_dl_mode && i_dl_active)) begin
            w_dl_mode_nxt  = 1'b1;
            w_sys_resb_nxt = 1'b0;
            w_hold_nxt     = HW'(HOLD);
        end else begin
            w_dl_mode_nxt = 1'b0;
            if (r_hold != '0) begin
                w_hold_nxt = r_hold - HW'(1);
            end else begin
                w_sys_resb_nxt = 1'b1;
            end
        end

        w_dl_ready_nxt = (w_state_nxt == S_IDLE) && i_dl_active;
    end

    assign o_dl_ready   = r_dl_ready;
    assign o_cpu_rvalid = r_cpu_rvalid;
    assign o_cpu_rdata  = r_cpu_rdata;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_we     = r_mem_we;
    assign o_mem_re     = r_mem_re;
    assign o_cart_size  = r_cart_size;
    assign o_sys_resb   = r_sys_resb;

endmodule

// File: tb/tb_cart_mem_ctrl.sv
// Directed bench for cart_mem_ctrl: downloads, a table of CPU reads against a
// latency-accurate memory model, download/read collision, address boundary and reset abort.
module tb_cart_mem_ctrl;

    localparam int unsigned AW     = 17;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned HOLD   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dl_active = 1'b0;
    logic          dl_valid = 1'b0;
    logic [AW-1:0] dl_addr = '0;
    logic [7:0]    dl_data = '0;
    logic          cpu_req = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    mem_rdata;
    logic          o_dl_ready, o_cpu_rvalid, o_mem_we, o_mem_re, o_sys_resb;
    logic [7:0]    o_cpu_rdata, o_mem_wdata;
    logic [AW-1:0] o_mem_addr;
    logic [AW:0]   o_cart_size;

    int n_checks = 0;
    int n_fail   = 0;

    cart_mem_ctrl #(.AW(AW), .RD_LAT(RD_LAT), .HOLD(HOLD)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_dl_active(dl_active), .i_dl_valid(dl_valid), .i_dl_addr(dl_addr),
        .i_dl_data(dl_data), .o_dl_ready(o_dl_ready),
        .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .o_cpu_rdata(o_cpu_rdata),
        .o_cpu_rvalid(o_cpu_rvalid),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
        .o_mem_re(o_mem_re), .i_mem_rdata(mem_rdata),
        .o_cart_size(o_cart_size), .o_sys_resb(o_sys_resb)
    );

    always #5 clk = ~clk;

    // Memory model: data valid RD_LAT cycles after the MEM_RE cycle, garbage otherwise
    logic [7:0]    mem [0:(1<<AW)-1];
    logic          re_pipe [RD_LAT];
    logic [AW-1:0] ap_pipe [RD_LAT];
    always @(posedge clk) begin
        if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
        re_pipe[0] <= o_mem_re;
        ap_pipe[0] <= o_mem_addr;
        for (int j = 1; j < RD_LAT; j++) begin
            re_pipe[j] <= re_pipe[j-1];
            ap_pipe[j] <= ap_pipe[j-1];
        end
    end
    assign mem_rdata = re_pipe[RD_LAT-1] ? mem[ap_pipe[RD_LAT-1]] : 8'hEE;

    // Write-strobe monitor: spacing within a burst, READY during DL_WR, WE/RE overlap
    int burst_id  = 0;
    int mcyc      = 0;
    int last_we   = 0;
    int last_bid  = -1;
    int we_cnt    = 0;
    int gap_bad   = 0;
    int ready_bad = 0;
    int ovl_bad   = 0;
    always @(negedge clk) begin
        mcyc <= mcyc + 1;
        if (o_mem_we) begin
            we_cnt <= we_cnt + 1;
            if (last_bid == burst_id && (mcyc - last_we) != 2) gap_bad <= gap_bad + 1;
            last_we  <= mcyc;
            last_bid <= burst_id;
            if (o_dl_ready) ready_bad <= ready_bad + 1;
        end
        if (o_mem_we && o_mem_re) ovl_bad <= ovl_bad + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"},  32'(o_dl_ready),   0);
        chk({tag, "_rvalid"}, 32'(o_cpu_rvalid), 0);
        chk({tag, "_rdata"},  32'(o_cpu_rdata),  32'hFF);
        chk({tag, "_strobes"}, 32'({o_mem_we, o_mem_re}), 0);
        chk({tag, "_maddr"},  32'(o_mem_addr),   0);
        chk({tag, "_wdata"},  32'(o_mem_wdata),  0);
        chk({tag, "_size"},   32'(o_cart_size),  0);
        chk({tag, "_sysresb"}, 32'(o_sys_resb),  0);
    endtask

    // SYS_RESB must stay low for HOLD cycles and rise on the next
    task automatic chk_hold(input string tag);
        repeat (HOLD) tick();
        chk({tag, "_hold_low"}, 32'(o_sys_resb), 0);
        tick();
        chk({tag, "_hold_rise"}, 32'(o_sys_resb), 1);
    endtask

    task automatic dl_burst(input logic [AW-1:0] start, input int n, input logic [7:0] base);
        int i;
        int guard;
        logic acc;
        i = 0;
        guard = 0;
        burst_id = burst_id + 1;
        dl_valid = 1'b1;
        dl_addr  = start;
        dl_data  = base;
        while (i < n && guard < 200) begin
            @(negedge clk);
            acc = o_dl_ready;
            tick();
            guard++;
            if (acc) begin
                i++;
                dl_addr = start + AW'(i);
                dl_data = base + 8'(i);
            end
        end
        dl_valid = 1'b0;
        if (guard >= 200) chk("dl_burst_timeout", 32'(i), 32'(n));
    endtask

    task automatic do_read(input logic [AW-1:0] a, output int lat, output logic re_first,
                           output logic extra_re, output logic [7:0] data);
        logic got;
        got = 1'b0;
        lat = 0;
        re_first = 1'b0;
        extra_re = 1'b0;
        cpu_addr = a;
        cpu_req  = 1'b1;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (lat == 1) re_first = o_mem_re;
            else if (o_mem_re) extra_re = 1'b1;
            if (o_cpu_rvalid) got = 1'b1;
        end
        cpu_req = 1'b0;
        data = o_cpu_rdata;
        if (!got) lat = 99;
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          exp_re;
        logic [7:0]    exp_data;
        int            exp_lat;
    } rd_vec_t;

    rd_vec_t rv [6];

    initial begin
        int lat;
        int we_base;
        logic re_first, extra_re;
        logic [7:0] data;

        rv[0] = '{17'h00000, 1'b1, 8'hA0, RD_LAT + 2};
        rv[1] = '{17'h00005, 1'b1, 8'hA5, RD_LAT + 2};
        rv[2] = '{17'h0000F, 1'b1, 8'hAF, RD_LAT + 2};
        rv[3] = '{17'h00010, 1'b0, 8'hFF, 1};
        rv[4] = '{17'h00020, 1'b0, 8'hFF, 1};
        rv[5] = '{17'h1FFFF, 1'b0, 8'hFF, 1};

        // Power-on reset and release hold
        repeat (3) tick();
        chk_reset_state("por");
        @(negedge clk);
        rst_n = 1'b1;
        chk_hold("por");

        // Full-rate download of 0x00..0x0F
        dl_active = 1'b1;
        tick();
        tick();
        chk("dl_start_sysresb", 32'(o_sys_resb), 0);
        we_base = we_cnt;
        dl_burst(17'h00000, 16, 8'hA0);
        tick();
        tick();
        chk("dl_we_count", 32'(we_cnt - we_base), 16);
        chk("dl_size16", 32'(o_cart_size), 16);
        chk("dl_we_gap", 32'(gap_bad), 0);
        chk("dl_ready_in_wr", 32'(ready_bad), 0);
        chk("dl_sysresb_during", 32'(o_sys_resb), 0);
        dl_active = 1'b0;
        chk_hold("dl_end");

        // Table of CPU reads (in range, out of range, boundary of CART_SIZE)
        for (int k = 0; k < 6; k++) begin
            do_read(rv[k].addr, lat, re_first, extra_re, data);
            chk($sformatf("rd%0d_lat", k), 32'(lat), 32'(rv[k].exp_lat));
            chk($sformatf("rd%0d_re", k), 32'(re_first), 32'(rv[k].exp_re));
            chk($sformatf("rd%0d_extra_re", k), 32'(extra_re), 0);
            chk($sformatf("rd%0d_data", k), 32'(data), 32'(rv[k].exp_data));
            tick();
            chk($sformatf("rd%0d_pulse", k), 32'(o_cpu_rvalid), 0);
            chk($sformatf("rd%0d_hold", k), 32'(o_cpu_rdata), 32'(rv[k].exp_data));
        end

        // Collision: download starts while a read is waiting on memory
        cpu_addr = 17'h00003;
        cpu_req  = 1'b1;
        tick();
        chk("col_re", 32'(o_mem_re), 1);
        dl_active = 1'b1;
        lat = 1;
        while (!o_cpu_rvalid && lat < 20) begin
            tick();
            lat++;
        end
        cpu_req = 1'b0;
        chk("col_lat", 32'(lat), RD_LAT + 2);
        chk("col_data", 32'(o_cpu_rdata), 32'hA3);
        chk("col_ready", 32'(o_dl_ready), 1);
        tick();
        chk("col_size_clr", 32'(o_cart_size), 0);
        chk("col_sysresb", 32'(o_sys_resb), 0);

        // Top-of-space writes: CART_SIZE must reach 2^AW without wrapping
        we_base = we_cnt;
        dl_burst(17'h1FFFD, 3, 8'h70);
        tick();
        tick();
        chk("top_size", 32'(o_cart_size), 32'h20000);
        chk("top_we_count", 32'(we_cnt - we_base), 3);
        chk("top_we_gap", 32'(gap_bad), 0);
        chk("top_ready_in_wr", 32'(ready_bad), 0);
        dl_active = 1'b0;
        chk_hold("top_end");
        do_read(17'h1FFFF, lat, re_first, extra_re, data);
        chk("top_rd_lat", 32'(lat), RD_LAT + 2);
        chk("top_rd_data", 32'(data), 32'h72);
        chk("we_re_overlap", 32'(ovl_bad), 0);

        // Reset in the middle of a read aborts it
        we_base = we_cnt;
        cpu_addr = 17'h00007;
        cpu_req  = 1'b1;
        tick();
        chk("rst_mid_re", 32'(o_mem_re), 1);
        rst_n   = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk_reset_state("rst_mid");
        tick();
        tick();
        tick();
        chk("rst_no_rvalid", 32'(o_cpu_rvalid), 0);
        chk("rst_no_write", 32'(we_cnt - we_base), 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk_hold("rst_rel");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
